// File: rtl/cmd_int_burst.sv
// ============================================================================
// Module      : cmd_int_burst
// Description : UART byte-stream command interpreter issuing burst register
//               writes/reads with address auto-increment and inter-byte timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cmd_int_burst #(
  parameter int ADDR_W      = 7,
  parameter int DATA_BYTES  = 1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_received_i,
  input  logic [7:0]              data_i,
  input  logic                    tx_ready_i,
  output logic                    data_valid_o,
  output logic [7:0]              data_o,
  output logic                    cmd_busy_o,
  output logic                    wr_o,
  output logic                    rd_o,
  output logic [ADDR_W-1:0]       address_o,
  output logic [8*DATA_BYTES-1:0] write_data_o,
  input  logic [8*DATA_BYTES-1:0] read_data_i,
  output logic                    timeout_o
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int TMR_W  = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BYTES - 1);
  localparam bit               ONE_BYTE = (DATA_BYTES == 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_WSTB  = 3'd3;
  localparam logic [2:0] S_RREQ  = 3'd4;
  localparam logic [2:0] S_RCAP  = 3'd5;
  localparam logic [2:0] S_RSEND = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [7:0]        r_rem;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_tx;
  logic [TMR_W-1:0]  r_timer;

  logic [DATA_W+7:0] w_word_cat;
  logic [DATA_W-1:0] w_word_nxt;
  logic              w_last;
  logic              w_timed;
  logic              w_expire;
  logic              w_tx_fire;

  // New bytes enter at the top so the first byte of a word ends up in [7:0].
  assign w_word_cat = {data_i, r_word};
  assign w_word_nxt = w_word_cat[DATA_W+7:8];
  assign w_last     = (r_idx == IDX_LAST);
  assign w_timed    = (r_state == S_LEN) || (r_state == S_WDATA);
  assign w_expire   = w_timed && (r_timer == TMR_LAST) && !data_received_i;
  assign w_tx_fire  = (r_state == S_RSEND) && tx_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (data_received_i) w_state_nxt = S_LEN;
      S_LEN: begin
        if (data_received_i) w_state_nxt = r_wr ? S_WDATA : S_RREQ;
        else if (w_expire)   w_state_nxt = S_IDLE;
      end
      S_WDATA: begin
        if (data_received_i) w_state_nxt = w_last ? S_WSTB : S_WDATA;
        else if (w_expire)   w_state_nxt = S_IDLE;
      end
      S_WSTB: begin
        if (r_rem == 8'd0)                    w_state_nxt = S_IDLE;
        else if (data_received_i && ONE_BYTE) w_state_nxt = S_WSTB;
        else                                  w_state_nxt = S_WDATA;
      end
      S_RREQ:  w_state_nxt = S_RCAP;
      S_RCAP:  w_state_nxt = S_RSEND;
      S_RSEND: if (w_tx_fire && w_last) w_state_nxt = (r_rem == 8'd0) ? S_IDLE : S_RREQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_busy_o   = (r_state != S_IDLE);
    wr_o         = (r_state == S_WSTB);
    rd_o         = (r_state == S_RREQ);
    data_valid_o = (r_state == S_RSEND);
    data_o       = (r_state == S_RSEND) ? r_tx[7:0] : 8'd0;
    address_o    = (wr_o || rd_o) ? r_addr : '0;
    write_data_o = wr_o ? r_word : '0;
    timeout_o    = w_expire;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_wr   <= 1'b0;
      r_rem  <= 8'd0;
      r_idx  <= 3'd0;
      r_word <= '0;
      r_tx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (data_received_i) begin
          r_addr <= data_i[ADDR_W-1:0];
          r_wr   <= data_i[7];
        end
        S_LEN: if (data_received_i) begin
          r_rem <= data_i;
          r_idx <= 3'd0;
        end
        S_WDATA: if (data_received_i) begin
          r_word <= w_word_nxt;
          r_idx  <= w_last ? 3'd0 : r_idx + 3'd1;
        end
        S_WSTB: begin
          if (r_rem != 8'd0) begin
            r_rem  <= r_rem - 8'd1;
            r_addr <= r_addr + ADDR_W'(1);
          end
          // A byte landing during the strobe cycle already belongs to the next word.
          if (data_received_i) begin
            r_word <= w_word_nxt;
            r_idx  <= ONE_BYTE ? 3'd0 : 3'd1;
          end else begin
            r_idx  <= 3'd0;
          end
        end
        S_RCAP: begin
          r_tx  <= read_data_i;
          r_idx <= 3'd0;
        end
        S_RSEND: if (tx_ready_i) begin
          r_tx <= r_tx >> 8;
          if (w_last) begin
            r_idx <= 3'd0;
            if (r_rem != 8'd0) begin
              r_rem  <= r_rem - 8'd1;
              r_addr <= r_addr + ADDR_W'(1);
            end
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                    r_timer <= '0;
    else if (data_received_i || w_expire)         r_timer <= '0;
    else if (w_timed || (r_state == S_WSTB))      r_timer <= r_timer + TMR_W'(1);
    else                                          r_timer <= '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_int_burst.sv
// ============================================================================
// Module      : tb_cmd_int_burst
// Description : Scoreboard bench for cmd_int_burst (1-byte and 2-byte words).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cmd_int_burst;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  localparam logic [1:0] K_WR = 2'd0;
  localparam logic [1:0] K_RD = 2'd1;
  localparam logic [1:0] K_TX = 2'd2;
  localparam logic [1:0] K_TO = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic rx_a = 1'b0, rx_b = 1'b0;
  logic tx_ready = 1'b0;

  logic dv_a, busy_a, wr_a, rd_a, to_a;
  logic [7:0] dout_a, wdata_a, rdd_a;
  logic [6:0] addr_a;
  logic dv_b, busy_b, wr_b, rd_b, to_b;
  logic [7:0] dout_b;
  logic [15:0] wdata_b;
  logic [15:0] rdd_b = 16'h0000;
  logic [6:0] addr_b;

  int total = 0;
  int bad = 0;
  ev_t exp_a[$];
  ev_t exp_b[$];

  always #5 clk = ~clk;

  cmd_int_burst #(.ADDR_W(7), .DATA_BYTES(1), .TIMEOUT_CYC(16)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .data_received_i(rx_a), .data_i(rx_data),
    .tx_ready_i(tx_ready), .data_valid_o(dv_a), .data_o(dout_a),
    .cmd_busy_o(busy_a), .wr_o(wr_a), .rd_o(rd_a), .address_o(addr_a),
    .write_data_o(wdata_a), .read_data_i(rdd_a), .timeout_o(to_a));

  cmd_int_burst #(.ADDR_W(7), .DATA_BYTES(2), .TIMEOUT_CYC(16)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .data_received_i(rx_b), .data_i(rx_data),
    .tx_ready_i(tx_ready), .data_valid_o(dv_b), .data_o(dout_b),
    .cmd_busy_o(busy_b), .wr_o(wr_b), .rd_o(rd_b), .address_o(addr_b),
    .write_data_o(wdata_b), .read_data_i(rdd_b), .timeout_o(to_b));

  // Register file model for A: reads return address + 0x40 one cycle after rd_o.
  always @(posedge clk) if (rd_a) rdd_a <= {1'b0, addr_a} + 8'h40;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic expect_ev(input bit sel, input logic [1:0] k, input logic [7:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    if (sel) exp_b.push_back(e);
    else     exp_a.push_back(e);
  endtask

  task automatic observe(input bit sel, input logic [1:0] k, input logic [7:0] a, input logic [15:0] d);
    ev_t e;
    if ((sel ? exp_b.size() : exp_a.size()) == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event dut=%0d: got kind=%0d addr=0x%0h data=0x%0h required none", sel, k, a, d);
    end else begin
      e = sel ? exp_b.pop_front() : exp_a.pop_front();
      chk(sel ? "b_kind" : "a_kind", {30'd0, k}, {30'd0, e.kind});
      chk(sel ? "b_addr" : "a_addr", {24'd0, a}, {24'd0, e.addr});
      chk(sel ? "b_data" : "a_data", {16'd0, d}, {16'd0, e.data});
    end
  endtask

  always @(negedge clk) begin
    if (wr_a)            observe(1'b0, K_WR, {1'b0, addr_a}, {8'd0, wdata_a});
    if (rd_a)            observe(1'b0, K_RD, {1'b0, addr_a}, 16'd0);
    if (dv_a && tx_ready) observe(1'b0, K_TX, 8'd0, {8'd0, dout_a});
    if (to_a)            observe(1'b0, K_TO, 8'd0, 16'd0);
  end

  always @(negedge clk) begin
    if (wr_b)            observe(1'b1, K_WR, {1'b0, addr_b}, wdata_b);
    if (rd_b)            observe(1'b1, K_RD, {1'b0, addr_b}, 16'd0);
    if (dv_b && tx_ready) observe(1'b1, K_TX, 8'd0, {8'd0, dout_b});
    if (to_b)            observe(1'b1, K_TO, 8'd0, 16'd0);
  end

  // Back-to-back one-cycle strobes; returns 1ns after the edge sampling the last byte.
  task automatic send(input bit sel, input byte_q_t q);
    foreach (q[i]) begin
      @(posedge clk); #1;
      rx_data = q[i];
      if (sel) rx_b = 1'b1; else rx_a = 1'b1;
    end
    @(posedge clk); #1;
    rx_a = 1'b0;
    rx_b = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    while ((sel ? busy_b : busy_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(sel ? "b_idle_in_time" : "a_idle_in_time", {31'd0, sel ? busy_b : busy_a}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish required finish by 300000");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_outs", {24'd0, wr_a, rd_a, dv_a, to_a, busy_b, wr_b, rd_b, dv_b}, 32'd0);
    chk("rst_buses", {addr_a, dout_a, wdata_a}, 32'd0);

    // Single write, latency one cycle after final byte.
    expect_ev(1'b0, K_WR, 8'h05, 16'h00A5);
    send(1'b0, '{8'h85, 8'h00, 8'hA5});
    @(negedge clk);
    chk("wr_latency", {31'd0, wr_a}, 32'd1);
    wait_idle(1'b0);

    // Back-to-back burst: bytes arriving during the write strobe start the next word.
    expect_ev(1'b0, K_WR, 8'h00, 16'h00A0);
    expect_ev(1'b0, K_WR, 8'h01, 16'h00A1);
    expect_ev(1'b0, K_WR, 8'h02, 16'h00A2);
    send(1'b0, '{8'h80, 8'h02, 8'hA0, 8'hA1, 8'hA2});
    wait_idle(1'b0);

    // Two-byte words, little-endian, address wraps 0x7F -> 0x00.
    expect_ev(1'b1, K_WR, 8'h7E, 16'h2211);
    expect_ev(1'b1, K_WR, 8'h7F, 16'h4433);
    expect_ev(1'b1, K_WR, 8'h00, 16'h6655);
    send(1'b1, '{8'hFE, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    wait_idle(1'b1);

    // Burst read with TX back-pressure.
    expect_ev(1'b0, K_RD, 8'h10, 16'h0000);
    expect_ev(1'b0, K_TX, 8'h00, 16'h0050);
    expect_ev(1'b0, K_RD, 8'h11, 16'h0000);
    expect_ev(1'b0, K_TX, 8'h00, 16'h0051);
    tx_ready = 1'b0;
    send(1'b0, '{8'h10, 8'h01});
    n = 0;
    @(negedge clk);
    while (!dv_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("tx_valid_seen", {31'd0, dv_a}, 32'd1);
    chk("tx_first_byte", {24'd0, dout_a}, 32'h50);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!dv_a || dout_a !== 8'h50) ok = 1'b0;
    end
    chk("tx_stall_hold", {31'd0, ok}, 32'd1);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle(1'b0);
    @(posedge clk); #1 tx_ready = 1'b0;

    // Silence after count byte: timeout in the 16th cycle, no write.
    expect_ev(1'b0, K_TO, 8'h00, 16'h0000);
    send(1'b0, '{8'h83, 8'h00});
    ok = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (to_a) ok = 1'b0;
    end
    chk("to_not_early", {31'd0, ok}, 32'd1);
    @(negedge clk);
    chk("to_pulse", {31'd0, to_a}, 32'd1);
    @(negedge clk);
    chk("to_busy_clear", {31'd0, busy_a}, 32'd0);
    chk("to_single_pulse", {31'd0, to_a}, 32'd0);

    // Byte arriving in the expiry cycle wins.
    expect_ev(1'b0, K_WR, 8'h03, 16'h0077);
    send(1'b0, '{8'h83, 8'h00});
    repeat (15) @(posedge clk);
    #1;
    rx_data = 8'h77;
    rx_a = 1'b1;
    @(negedge clk);
    chk("expiry_byte_no_to", {31'd0, to_a}, 32'd0);
    @(posedge clk); #1 rx_a = 1'b0;
    @(negedge clk);
    chk("expiry_byte_wr", {31'd0, wr_a}, 32'd1);
    wait_idle(1'b0);

    // Asynchronous reset mid-burst, then a clean frame.
    expect_ev(1'b0, K_WR, 8'h01, 16'h0011);
    send(1'b0, '{8'h81, 8'h03, 8'h11});
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_outs", {27'd0, busy_a, wr_a, rd_a, dv_a, to_a}, 32'd0);
    chk("async_rst_buses", {addr_a, dout_a, wdata_a}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_ev(1'b0, K_WR, 8'h01, 16'h003C);
    send(1'b0, '{8'h81, 8'h00, 8'h3C});
    @(negedge clk);
    chk("post_rst_wr", {31'd0, wr_a}, 32'd1);
    wait_idle(1'b0);

    repeat (5) @(negedge clk);
    chk("a_events_left", exp_a.size(), 32'd0);
    chk("b_events_left", exp_b.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
